sys_bus_arbiter: RTL

Two-master, four-slave arbiter and sequencer for the compy system bus. It shares the ROM, RAM, chroni register window and I/O board between the 6502 CPU (master 0) and a DMA engine (master 1). It decodes addresses to chip selects, inserts the read wait states the synchronous slaves need, and returns per-master acknowledge and read data. It replaces the ad-hoc bus_state/cpu_ready logic at system level.

---
 rtl/sys_bus_arbiter_pkg.sv | 36 +++
 rtl/sys_bus_arbiter_if.sv | 50 +++++
 rtl/sys_bus_arbiter_decode.sv | 20 ++
 rtl/sys_bus_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sys_bus_arbiter_pkg.sv
// Shared types for the compy system bus arbiter: bus states, master ids,
// chip-select payload and default parameter values.
package sys_bus_arbiter_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BURST_W = 4;
  localparam int unsigned WAIT_W  = 3;

  localparam int unsigned        READ_WAIT_DEF     = 1;
  localparam int unsigned        DMA_BURST_MAX_DEF = 4;
  localparam logic [DATA_W-1:0]  UNMAPPED_DATA_DEF = 8'hFF;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_ACCESS,
    BUS_WAIT,
    BUS_CAPTURE,
    BUS_DONE
  } bus_state_e;

  typedef enum logic {
    BUS_M_CPU = 1'b0,
    BUS_M_DMA = 1'b1
  } bus_master_e;

  typedef struct packed {
    logic rom;
    logic ram;
    logic chroni;
    logic io;
  } bus_cs_t;

  localparam bus_cs_t CS_NONE = '0;

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Bundle of both master ports and the shared slave side of the system bus.
interface sys_bus_arbiter_if;
  import sys_bus_arbiter_pkg::*;

  logic [ADDR_W-1:0] m0_addr;
  logic              m0_rd_req;
  logic              m0_wr_en;
  logic [DATA_W-1:0] m0_wr_data;
  logic [DATA_W-1:0] m0_rd_data;
  logic              m0_ack;

  logic [ADDR_W-1:0] m1_addr;
  logic              m1_rd_req;
  logic              m1_wr_en;
  logic [DATA_W-1:0] m1_wr_data;
  logic [DATA_W-1:0] m1_rd_data;
  logic              m1_ack;

  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wr_data;
  logic              s_wr_en;
  logic              rom_cs;
  logic              ram_cs;
  logic              chroni_cs;
  logic              io_cs;
  logic [DATA_W-1:0] rom_rd_data;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] chroni_rd_data;
  logic [DATA_W-1:0] io_rd_data;

  // Arbiter side: it is the slave of both masters.
  modport slave (
    input  m0_addr, m0_rd_req, m0_wr_en, m0_wr_data,
    output m0_rd_data, m0_ack,
    input  m1_addr, m1_rd_req, m1_wr_en, m1_wr_data,
    output m1_rd_data, m1_ack,
    output s_addr, s_wr_data, s_wr_en, rom_cs, ram_cs, chroni_cs, io_cs,
    input  rom_rd_data, ram_rd_data, chroni_rd_data, io_rd_data
  );

  modport master (
    output m0_addr, m0_rd_req, m0_wr_en, m0_wr_data,
    input  m0_rd_data, m0_ack,
    output m1_addr, m1_rd_req, m1_wr_en, m1_wr_data,
    input  m1_rd_data, m1_ack,
    input  s_addr, s_wr_data, s_wr_en, rom_cs, ram_cs, chroni_cs, io_cs,
    output rom_rd_data, ram_rd_data, chroni_rd_data, io_rd_data
  );

endinterface

// File: rtl/sys_bus_arbiter_decode.sv
// Address to slave-select decode; also reused by the DMA engine for range checks.
module sys_bus_arbiter_decode
  import sys_bus_arbiter_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output bus_cs_t           cs_o,
  output logic              mapped_o
);

  always_comb begin
    cs_o        = CS_NONE;
    cs_o.rom    = (addr_i[15:14] == 2'b11);
    cs_o.ram    = !addr_i[15] || (addr_i[15:12] == 4'h8);
    cs_o.chroni = (addr_i[15:7] == 9'b100100000);
    cs_o.io     = (addr_i[15:8] == 8'h92);
  end

  assign mapped_o = |cs_o;

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master / four-slave system bus arbiter: grants CPU or DMA, drives chip
// selects, inserts read wait states and returns per-master ack and read data.
module sys_bus_arbiter
  import sys_bus_arbiter_pkg::*;
#(
  parameter int unsigned       READ_WAIT     = READ_WAIT_DEF,
  parameter int unsigned       DMA_BURST_MAX = DMA_BURST_MAX_DEF,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = UNMAPPED_DATA_DEF
) (
  input logic              clk,
  input logic              reset,
  sys_bus_arbiter_if.slave bus
);

  bus_state_e        state_q;
  bus_master_e       master_q;
  logic              wr_q;
  logic [WAIT_W-1:0] wait_q;
  logic [BURST_W-1:0] burst_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [DATA_W-1:0] s_wr_data_q;
  logic              s_wr_en_q;
  bus_cs_t           cs_q;
  logic [DATA_W-1:0] m0_rd_data_q, m1_rd_data_q;
  logic              m0_ack_q, m1_ack_q;

  logic              m0_req_c, m1_req_c, grant_m1_c;
  logic [ADDR_W-1:0] req_addr_c;
  logic [DATA_W-1:0] req_data_c;
  logic              req_wr_c;
  bus_cs_t           req_cs_c;
  logic              req_mapped_c;
  logic [DATA_W-1:0] capture_d;

  assign m0_req_c = bus.m0_rd_req || bus.m0_wr_en;
  assign m1_req_c = bus.m1_rd_req || bus.m1_wr_en;
  // DMA wins contention until it has taken DMA_BURST_MAX grants in a row.
  assign grant_m1_c = m1_req_c && (!m0_req_c || (burst_q != BURST_W'(DMA_BURST_MAX)));

  assign req_addr_c = grant_m1_c ? bus.m1_addr    : bus.m0_addr;
  assign req_data_c = grant_m1_c ? bus.m1_wr_data : bus.m0_wr_data;
  assign req_wr_c   = grant_m1_c ? bus.m1_wr_en   : bus.m0_wr_en;

  sys_bus_arbiter_decode u_decode (
    .addr_i   (req_addr_c),
    .cs_o     (req_cs_c),
    .mapped_o (req_mapped_c)
  );

  always_comb begin
    capture_d = UNMAPPED_DATA;
    if      (cs_q.rom)    capture_d = bus.rom_rd_data;
    else if (cs_q.ram)    capture_d = bus.ram_rd_data;
    else if (cs_q.chroni) capture_d = bus.chroni_rd_data;
    else if (cs_q.io)     capture_d = bus.io_rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BUS_IDLE;
      master_q     <= BUS_M_CPU;
      wr_q         <= 1'b0;
      wait_q       <= '0;
      burst_q      <= '0;
      s_addr_q     <= '0;
      s_wr_data_q  <= '0;
      s_wr_en_q    <= 1'b0;
      cs_q         <= CS_NONE;
      m0_rd_data_q <= '0;
      m1_rd_data_q <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
    end else begin
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      s_wr_en_q <= 1'b0;
      unique case (state_q)
        BUS_IDLE: begin
          burst_q <= (m0_req_c && grant_m1_c) ? burst_q + BURST_W'(1) : '0;
          if (m0_req_c || m1_req_c) begin
            master_q    <= grant_m1_c ? BUS_M_DMA : BUS_M_CPU;
            wr_q        <= req_wr_c;
            s_addr_q    <= req_addr_c;
            s_wr_data_q <= req_data_c;
            cs_q        <= req_cs_c;
            wait_q      <= WAIT_W'(READ_WAIT - 1);
            state_q     <= BUS_ACCESS;
            // Writes complete in the access cycle, so strobe and ack launch together.
            if (req_wr_c) begin
              s_wr_en_q <= req_mapped_c;
              m0_ack_q  <= !grant_m1_c;
              m1_ack_q  <= grant_m1_c;
            end
          end
        end
        BUS_ACCESS: begin
          if (wr_q) begin
            cs_q    <= CS_NONE;
            state_q <= BUS_IDLE;
          end else if (wait_q == '0) begin
            state_q <= BUS_CAPTURE;
          end else begin
            state_q <= BUS_WAIT;
          end
        end
        BUS_WAIT: begin
          wait_q <= wait_q - WAIT_W'(1);
          if (wait_q == WAIT_W'(1)) state_q <= BUS_CAPTURE;
        end
        BUS_CAPTURE: begin
          if (master_q == BUS_M_DMA) begin
            m1_rd_data_q <= capture_d;
            m1_ack_q     <= 1'b1;
          end else begin
            m0_rd_data_q <= capture_d;
            m0_ack_q     <= 1'b1;
          end
          cs_q    <= CS_NONE;
          state_q <= BUS_DONE;
        end
        BUS_DONE: state_q <= BUS_IDLE;
        default:  state_q <= BUS_IDLE;
      endcase
    end
  end

  assign bus.s_addr     = s_addr_q;
  assign bus.s_wr_data  = s_wr_data_q;
  assign bus.s_wr_en    = s_wr_en_q;
  assign bus.rom_cs     = cs_q.rom;
  assign bus.ram_cs     = cs_q.ram;
  assign bus.chroni_cs  = cs_q.chroni;
  assign bus.io_cs      = cs_q.io;
  assign bus.m0_rd_data = m0_rd_data_q;
  assign bus.m1_rd_data = m1_rd_data_q;
  assign bus.m0_ack     = m0_ack_q;
  assign bus.m1_ack     = m1_ack_q;

endmodule
